clk_switch_ctrl: RTL and testbench

Control-side partner of the glitchless clock multiplexer. It accepts clock-source change requests from the core (SFR write path), drives the mux select, and confirms the switch by watching the select value sampled back in the muxed-clock domain. It reports completion, or a timeout error when the new source never takes over. It runs on a free-running system clock that is never switched.

---
 rtl/clk_switch_ctrl_pkg.sv | 15 +
 rtl/clk_switch_ctrl_sync_2ff.sv | 23 ++
 rtl/clk_switch_ctrl.sv | 110 +++++++++++
 tb/tb_clk_switch_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/clk_switch_ctrl_pkg.sv
// rtl/clk_switch_ctrl_pkg.sv - state encodings and default parameters for the clock switch controller
package clk_switch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_SETTLE   = 2'd2
    } state_t;

    localparam logic DEF_RESET_SEL      = 1'b0;
    localparam int   DEF_SETTLE_CYCLES  = 8;
    localparam int   DEF_TIMEOUT_CYCLES = 1024;
    localparam int   DEF_CNT_W          = 11;

endpackage

// File: rtl/clk_switch_ctrl_sync_2ff.sv
// rtl/clk_switch_ctrl_sync_2ff.sv - 1-bit two-flop synchronizer with parameterised reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_switch_ctrl.sv
// rtl/clk_switch_ctrl.sv - clock mux select controller with feedback confirmation and timeout
module clk_switch_ctrl
    import clk_switch_ctrl_pkg::*;
#(
    parameter logic RESET_SEL      = DEF_RESET_SEL,
    parameter int   SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int   TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int   CNT_W          = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    output logic sel,
    input  logic fb_sel,
    output logic busy,
    output logic done,
    output logic err
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic             sel_nxt, done_nxt, err_nxt;
    logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
    logic [CNT_W-1:0] st_cnt, st_cnt_nxt;
    logic             fb_s;
    logic             accept;

    sync_2ff #(.RESET_VAL(RESET_SEL)) u_fb_sync (
        .clk (clk),
        .rst (rst),
        .d   (fb_sel),
        .q   (fb_s)
    );

    assign req_ready = (state == ST_IDLE);
    assign busy      = ~req_ready;
    assign accept    = req_valid & req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            sel    <= RESET_SEL;
            done   <= 1'b0;
            err    <= 1'b0;
            to_cnt <= '0;
            st_cnt <= '0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            done   <= done_nxt;
            err    <= err_nxt;
            to_cnt <= to_cnt_nxt;
            st_cnt <= st_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        done_nxt   = 1'b0;
        err_nxt    = err;
        to_cnt_nxt = to_cnt;
        st_cnt_nxt = st_cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    err_nxt = 1'b0;
                    if (req_sel == sel) begin
                        done_nxt = 1'b1;
                    end else begin
                        sel_nxt    = req_sel;
                        to_cnt_nxt = '0;
                        state_nxt  = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                to_cnt_nxt = to_cnt + CNT_ONE;
                // A feedback match on the timeout edge still counts as success.
                if (fb_s == sel) begin
                    st_cnt_nxt = '0;
                    state_nxt  = ST_SETTLE;
                end else if (to_cnt == TO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                // to_cnt is held here so a glitch resumes the original timeout budget.
                if (fb_s != sel) begin
                    state_nxt = ST_WAIT_ACK;
                end else if (st_cnt == ST_LAST) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    st_cnt_nxt = st_cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb/tb_clk_switch_ctrl.sv - randomized self-checking bench for clk_switch_ctrl
module tb_clk_switch_ctrl;
    import clk_switch_ctrl_pkg::*;

    localparam int   S  = 8;
    localparam int   T  = 16;
    localparam int   H  = 64;
    localparam logic RS = 1'b0;

    logic clk       = 1'b0;
    logic rst       = 1'b0;
    logic req_valid = 1'b0;
    logic req_sel   = 1'b0;
    logic fb_sel    = 1'b0;
    logic req_ready, sel, busy, done, err;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic m_sel, m_err, prev_fb;
    logic fbw [H];

    clk_switch_ctrl #(
        .RESET_SEL      (RS),
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (DEF_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .sel       (sel),
        .fb_sel    (fb_sel),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Feedback as seen by the controller at edge E+k: driven after edge E+k-3.
    function automatic logic fbs_at(input int k);
        int j;
        j = k - 3;
        if (j < 0) return prev_fb;
        if (j >= H) j = H - 1;
        return fbw[j];
    endfunction

    // Completion edge offset: success after S+1 consecutive matching edges,
    // timeout at the T-th edge spent waiting for a match.
    function automatic int predict(input logic tgt, output bit tmo);
        int   waits;
        int   run;
        logic f;
        bit   in_wait;
        waits = 0;
        run   = 0;
        tmo   = 1'b0;
        for (int k = 1; k < 400; k++) begin
            f       = fbs_at(k);
            in_wait = (k == 1) || (fbs_at(k - 1) != tgt);
            if (in_wait) waits++;
            run = (f == tgt) ? run + 1 : 0;
            if (run == S + 1) return k;
            if (in_wait && (f != tgt) && (waits == T)) begin
                tmo = 1'b1;
                return k;
            end
        end
        tmo = 1'b1;
        return 400;
    endfunction

    task automatic do_reset(input string tag);
        #2;
        rst       = 1'b1;
        fb_sel    = RS;
        prev_fb   = RS;
        req_valid = 1'b0;
        #1;
        check_eq({tag, "_sel"},   sel,       RS);
        check_eq({tag, "_ready"}, req_ready, 1'b1);
        check_eq({tag, "_busy"},  busy,      1'b0);
        check_eq({tag, "_done"},  done,      1'b0);
        check_eq({tag, "_err"},   err,       1'b0);
        repeat (3) begin
            @(negedge clk);
            check_eq({tag, "_hold_done"}, done, 1'b0);
            check_eq({tag, "_hold_sel"},  sel,  RS);
        end
        rst   = 1'b0;
        m_sel = RS;
        m_err = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq({tag, "_post_done"}, done, 1'b0);
            check_eq({tag, "_post_busy"}, busy, 1'b0);
        end
    endtask

    task automatic run_txn(input logic tgt, input int kind, input int d, input bit spur, input int rst_at);
        int   k_end;
        bit   tmo;
        bit   noop;
        logic fb_now;
        for (int i = 0; i < H; i++) begin
            case (kind)
                0:       fbw[i] = (i < d) ? prev_fb : tgt;
                1:       fbw[i] = ~tgt;
                2:       fbw[i] = (i < d) ? prev_fb : ((i >= d + 5 && i < d + 8) ? ~tgt : tgt);
                default: fbw[i] = (i < d) ? logic'($urandom_range(0, 1)) : tgt;
            endcase
        end
        noop = (tgt == m_sel);
        tmo  = 1'b0;
        if (noop) k_end = 0;
        else      k_end = predict(tgt, tmo);

        @(negedge clk);
        req_valid = 1'b1;
        req_sel   = tgt;
        for (int i = 0; i <= k_end + 1; i++) begin
            @(negedge clk);
            check_eq("sel",   sel,       tgt);
            check_eq("busy",  busy,      i < k_end);
            check_eq("ready", req_ready, !(i < k_end));
            check_eq("done",  done,      (i == k_end) && !tmo);
            check_eq("err",   err,       (i >= k_end) && tmo);
            if (i == rst_at && i < k_end) begin
                do_reset("mid_rst");
                return;
            end
            fb_now    = fbw[(i < H) ? i : H - 1];
            fb_sel    = fb_now;
            prev_fb   = fb_now;
            req_valid = (spur && i < k_end) ? logic'($urandom_range(0, 1)) : 1'b0;
            req_sel   = logic'($urandom_range(0, 1));
        end
        req_valid = 1'b0;
        m_sel     = tgt;
        m_err     = tmo;
        repeat (3) begin
            @(negedge clk);
            check_eq("idle_done", done, 1'b0);
            check_eq("idle_err",  err,  m_err);
        end
    endtask

    initial begin
        int kind;
        int d;
        int ra;
        m_sel   = RS;
        m_err   = 1'b0;
        prev_fb = RS;
        @(negedge clk);
        do_reset("reset");

        run_txn(1'b1, 0, 4, 1'b0, -1);
        run_txn(1'b0, 0, 0, 1'b0, -1);
        run_txn(1'b0, 0, 0, 1'b0, -1);
        run_txn(1'b1, 1, 0, 1'b0, -1);
        run_txn(1'b1, 0, 0, 1'b0, -1);
        run_txn(1'b0, 2, 2, 1'b0, -1);
        run_txn(1'b1, 0, 3, 1'b1, -1);
        run_txn(1'b0, 0, 0, 1'b0, 6);

        repeat (40) begin
            kind = int'($urandom_range(0, 3));
            d    = (kind == 3) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 6));
            ra   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 10)) : -1;
            run_txn(logic'($urandom_range(0, 1)), kind, d, bit'($urandom_range(0, 1)), ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
